// File: rtl/led_pkg.sv
// Shared types and constants for the LED bank arbiter.
package led_pkg;

  localparam int LED_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } led_state_t;

  // Timer must count 0..max_hold-1; keep at least one bit for degenerate cases.
  function automatic int timer_width(input int max_hold);
    return (max_hold > 1) ? $clog2(max_hold) : 1;
  endfunction

endpackage

// File: rtl/led_arbiter_rr_picker.sv
// Round-robin picker: first set bit of (req & ~excl) at or after ptr, wrapping.
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic [N-1:0]  excl,
  output logic [N-1:0]  win,
  output logic          valid
);

  logic [N-1:0] masked;

  assign masked = req & ~excl;

  always_comb begin
    int idx;
    win = '0;
    idx = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (win == '0 && masked[idx[PW-1:0]]) win[idx[PW-1:0]] = 1'b1;
    end
  end

  assign valid = |win;

endmodule

// File: rtl/led_arbiter.sv
// Round-robin owner of the 8-bit LED bank with minimum dwell and maximum hold.
//   state | meaning
//   IDLE  | nobody owns the bank, leds = IDLE_PATTERN
//   OWNED | grant one-hot, leds track the owner's pattern while it requests
module led_arbiter
  import led_pkg::*;
#(
  parameter int           N_REQ        = 4,
  parameter int           DWELL        = 1000,
  parameter int           MAX_HOLD     = 50000,
  parameter logic [7:0]   IDLE_PATTERN = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [LED_W*N_REQ-1:0] pattern,
  output logic [N_REQ-1:0]       grant,
  output logic [LED_W-1:0]       leds,
  output logic                   busy
);

  localparam int          PW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int          TW       = timer_width(MAX_HOLD);
  localparam logic [31:0] DWELL_M1 = 32'(DWELL - 1);
  localparam logic [31:0] HOLD_M1  = 32'(MAX_HOLD - 1);

  led_state_t         state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [LED_W-1:0]   leds_q, leds_d;

  logic [PW-1:0]      owner_idx, next_idx, pick_ptr;
  logic [N_REQ-1:0]   pick_excl, pick_win;
  logic               pick_valid;
  logic [LED_W-1:0]   own_pat, pick_pat;
  logic [31:0]        timer_ext;
  logic               own_req, other_req, release_c;

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant_q[i]) owner_idx = PW'(i);
  end

  assign next_idx = (owner_idx == PW'(N_REQ - 1)) ? '0 : owner_idx + PW'(1);

  // While owned, the same picker searches from owner+1 with the owner masked out.
  assign pick_ptr  = (state_q == OWNED) ? next_idx : ptr_q;
  assign pick_excl = (state_q == OWNED) ? grant_q : '0;

  rr_picker #(.N(N_REQ), .PW(PW)) u_picker (
    .req   (req),
    .ptr   (pick_ptr),
    .excl  (pick_excl),
    .win   (pick_win),
    .valid (pick_valid)
  );

  always_comb begin
    own_pat  = '0;
    pick_pat = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i])  own_pat  = own_pat  | pattern[LED_W*i +: LED_W];
      if (pick_win[i]) pick_pat = pick_pat | pattern[LED_W*i +: LED_W];
    end
  end

  assign timer_ext = 32'(timer_q);
  assign own_req   = |(req & grant_q);
  assign other_req = |(req & ~grant_q);
  assign release_c = (!own_req && timer_ext >= DWELL_M1) ||
                     (timer_ext == HOLD_M1 && other_req);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    leds_d  = leds_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = OWNED;
          grant_d = pick_win;
          timer_d = '0;
          leds_d  = pick_pat;
        end
      end
      OWNED: begin
        if (release_c) begin
          ptr_d   = next_idx;
          timer_d = '0;
          if (pick_valid) begin
            grant_d = pick_win;
            leds_d  = pick_pat;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            leds_d  = IDLE_PATTERN;
          end
        end else begin
          if (timer_ext != HOLD_M1) timer_d = timer_q + TW'(1);
          if (own_req) leds_d = own_pat;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        timer_d = '0;
        leds_d  = IDLE_PATTERN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      timer_q <= '0;
      leds_q  <= IDLE_PATTERN;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
      leds_q  <= leds_d;
    end
  end

  assign grant = grant_q;
  assign leds  = leds_q;
  assign busy  = |grant_q;

endmodule

// File: tb/tb_led_arbiter.sv
// Directed bench for led_arbiter with N_REQ=4, DWELL=4, MAX_HOLD=16, IDLE_PATTERN=A5.
module tb_led_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] pattern;
  logic [3:0]  grant;
  logic [7:0]  leds;
  logic        busy;

  int tests;
  int fails;

  led_arbiter #(
    .N_REQ(4), .DWELL(4), .MAX_HOLD(16), .IDLE_PATTERN(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .pattern(pattern),
    .grant(grant), .leds(leds), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    req     = 4'b0000;
    pattern = 32'h0;
    @(negedge clk);
    tests++;
    if (leds !== 8'hA5) begin fails++; $display("FAIL reset_leds got=%h exp=a5", leds); end
    tests++;
    if (grant !== 4'b0000) begin fails++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    pattern[7:0] = 8'h11;
    req = 4'b0001;
    @(negedge clk);
    tests++;
    if (grant !== 4'b0001 || leds !== 8'h11) begin
      fails++; $display("FAIL midrst_pre grant=%b leds=%h exp 0001/11", grant, leds);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (grant !== 4'b0000 || leds !== 8'hA5 || busy !== 1'b0) begin
      fails++; $display("FAIL midrst_async grant=%b leds=%h busy=%b exp 0000/a5/0", grant, leds, busy);
    end
    req = 4'b0000;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_pulse();
    apply_reset();
    @(negedge clk);
    pattern[15:8] = 8'h3C;
    req = 4'b0010;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      req = 4'b0000;
      tests++;
      if (grant !== 4'b0010 || leds !== 8'h3C || busy !== 1'b1) begin
        fails++; $display("FAIL pulse_dwell cyc=%0d grant=%b leds=%h busy=%b exp 0010/3c/1", k, grant, leds, busy);
      end
    end
    @(negedge clk);
    tests++;
    if (grant !== 4'b0000 || leds !== 8'hA5 || busy !== 1'b0) begin
      fails++; $display("FAIL pulse_idle grant=%b leds=%h busy=%b exp 0000/a5/0", grant, leds, busy);
    end
  endtask

  task automatic test_rotate();
    logic [3:0] exp_g;
    logic [7:0] exp_l;
    int owner;
    apply_reset();
    pattern = 32'h44_33_22_11;
    @(negedge clk);
    req = 4'b1111;
    for (int c = 0; c < 65; c++) begin
      @(negedge clk);
      owner = (c / 16) % 4;
      exp_g = 4'b0001 << owner;
      exp_l = 8'h11 * 8'(owner + 1);
      tests++;
      if (grant !== exp_g || leds !== exp_l) begin
        fails++; $display("FAIL rotate cyc=%0d grant=%b leds=%h exp %b/%h", c, grant, leds, exp_g, exp_l);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_sole();
    apply_reset();
    pattern[23:16] = 8'h5A;
    @(negedge clk);
    req = 4'b0100;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      tests++;
      if (grant !== 4'b0100 || leds !== 8'h5A) begin
        fails++; $display("FAIL sole cyc=%0d grant=%b leds=%h exp 0100/5a", c, grant, leds);
      end
    end
    req = 4'b0000;
    @(negedge clk);
    tests++;
    if (grant !== 4'b0000 || leds !== 8'hA5) begin
      fails++; $display("FAIL sole_release grant=%b leds=%h exp 0000/a5", grant, leds);
    end
  endtask

  task automatic test_pattern();
    apply_reset();
    pattern[7:0]   = 8'h01;
    pattern[31:24] = 8'h77;
    @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
    tests++;
    if (grant !== 4'b0001 || leds !== 8'h01) begin
      fails++; $display("FAIL pat_start grant=%b leds=%h exp 0001/01", grant, leds);
    end
    pattern[7:0] = 8'h80;
    #1;
    tests++;
    if (leds !== 8'h01) begin fails++; $display("FAIL pat_no_comb_path got=%h exp=01", leds); end
    @(negedge clk);
    tests++;
    if (leds !== 8'h80) begin fails++; $display("FAIL pat_follow got=%h exp=80", leds); end
    pattern[31:24] = 8'hEE;
    @(negedge clk);
    tests++;
    if (leds !== 8'h80 || grant !== 4'b0001) begin
      fails++; $display("FAIL pat_nonowner leds=%h grant=%b exp 80/0001", leds, grant);
    end
    req = 4'b0000;
  endtask

  task automatic test_drop_handoff();
    apply_reset();
    pattern = 32'hD3_C2_B1_A0;
    @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    req = 4'b1000;
    @(negedge clk);
    tests++;
    if (grant !== 4'b0010) begin fails++; $display("FAIL drop_hold got=%b exp=0010", grant); end
    @(negedge clk);
    tests++;
    if (grant !== 4'b1000 || leds !== 8'hD3) begin
      fails++; $display("FAIL drop_handoff grant=%b leds=%h exp 1000/d3", grant, leds);
    end
    req = 4'b0000;
    for (int c = 0; c < 3; c++) @(negedge clk);
    tests++;
    if (grant !== 4'b1000) begin fails++; $display("FAIL drop_dwell3 got=%b exp=1000", grant); end
    @(negedge clk);
    tests++;
    if (grant !== 4'b0000 || leds !== 8'hA5) begin
      fails++; $display("FAIL drop_idle grant=%b leds=%h exp 0000/a5", grant, leds);
    end
    req = 4'b0101;
    @(negedge clk);
    tests++;
    if (grant !== 4'b0001 || leds !== 8'hA0) begin
      fails++; $display("FAIL ptr_wrap grant=%b leds=%h exp 0001/a0", grant, leds);
    end
    req = 4'b0000;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_reset_mid();
    test_pulse();
    test_rotate();
    test_sole();
    test_pattern();
    test_drop_handoff();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
